// File: rtl/ct_sysio_lpmd_ctrl_if.sv
// Low-power handshake bundle shared by the core, the sysio low-power
// controller and the SoC power controller.
interface ct_sysio_lpmd_ctrl_if;
   logic [1:0] piu_sysio_lpmd_b;
   logic [5:0] sysio_piu_int_vec;
   logic       pad_core_dbgrq_b;
   logic       pad_sysio_lpmd_ack;
   logic       sysio_lpmd_err_clr;
   logic [1:0] core_pad_lpmd_b;
   logic       sysio_ciu_icg_off;
   logic       sysio_piu_wakeup;
   logic       sysio_lpmd_busy;
   logic       sysio_lpmd_to_err;

   modport master (
      input  piu_sysio_lpmd_b,
      input  sysio_piu_int_vec,
      input  pad_core_dbgrq_b,
      input  pad_sysio_lpmd_ack,
      input  sysio_lpmd_err_clr,
      output core_pad_lpmd_b,
      output sysio_ciu_icg_off,
      output sysio_piu_wakeup,
      output sysio_lpmd_busy,
      output sysio_lpmd_to_err
   );

   modport slave (
      output piu_sysio_lpmd_b,
      output sysio_piu_int_vec,
      output pad_core_dbgrq_b,
      output pad_sysio_lpmd_ack,
      output sysio_lpmd_err_clr,
      input  core_pad_lpmd_b,
      input  sysio_ciu_icg_off,
      input  sysio_piu_wakeup,
      input  sysio_lpmd_busy,
      input  sysio_lpmd_to_err
   );
endinterface

// File: rtl/ct_sysio_lpmd_ctrl.sv
// Core low-power entry/exit sequencer: hands the core's wait/stop request to
// the pad power controller, gates core clocks and issues the wakeup pulse.
//
// state  | meaning
// RUN    | core running, pad sees 11, watching for a low-power request
// ENTER  | mode presented to pad, waiting for ack (wake aborts to EXIT)
// LOWPWR | ack received, core clocks gated, waiting for wake
// EXIT   | pad sees 11 again, waiting for ack to drop, then wakeup pulse
module ct_sysio_lpmd_ctrl #(
   parameter logic [7:0] ACK_TO = 8'd255
) (
   input logic                   sysio_clk,
   input logic                   cpurst_b,
   input logic                   axim_clk_en,
   ct_sysio_lpmd_ctrl_if.master  lpmd
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ENTER  = 2'd1,
      ST_LOWPWR = 2'd2,
      ST_EXIT   = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] timer, timer_nxt, timer_inc;
   logic [1:0] lpmd_out, lpmd_out_nxt;
   logic       icg_off, icg_off_nxt;
   logic       wakeup, wakeup_nxt;
   logic       busy, busy_nxt;
   logic       to_err, to_err_nxt;
   logic       err_set;
   logic       wake;
   logic       lp_req;
   logic       timeout;

   assign wake      = (|lpmd.sysio_piu_int_vec) | ~lpmd.pad_core_dbgrq_b;
   assign lp_req    = (lpmd.piu_sysio_lpmd_b == 2'b01) || (lpmd.piu_sysio_lpmd_b == 2'b00);
   // Timer saturates at ACK_TO; the abort fires on the edge it reaches it.
   assign timer_inc = (timer == ACK_TO) ? timer : timer + 8'd1;
   assign timeout   = (timer_inc == ACK_TO);

   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      lpmd_out_nxt = lpmd_out;
      icg_off_nxt  = icg_off;
      wakeup_nxt   = 1'b0;
      err_set      = 1'b0;
      case (state)
         ST_RUN: begin
            lpmd_out_nxt = 2'b11;
            if (lp_req && !wake) begin
               state_nxt    = ST_ENTER;
               lpmd_out_nxt = lpmd.piu_sysio_lpmd_b;
               timer_nxt    = 8'd0;
            end
         end
         ST_ENTER: begin
            if (wake) begin
               state_nxt    = ST_EXIT;
               lpmd_out_nxt = 2'b11;
               timer_nxt    = 8'd0;
            end else if (lpmd.pad_sysio_lpmd_ack) begin
               state_nxt   = ST_LOWPWR;
               icg_off_nxt = 1'b1;
            end else begin
               timer_nxt = timer_inc;
               if (timeout) begin
                  state_nxt    = ST_RUN;
                  lpmd_out_nxt = 2'b11;
                  err_set      = 1'b1;
               end
            end
         end
         ST_LOWPWR: begin
            if (wake) begin
               state_nxt    = ST_EXIT;
               icg_off_nxt  = 1'b0;
               lpmd_out_nxt = 2'b11;
               timer_nxt    = 8'd0;
            end
         end
         ST_EXIT: begin
            if (!lpmd.pad_sysio_lpmd_ack) begin
               state_nxt  = ST_RUN;
               wakeup_nxt = 1'b1;
            end else begin
               timer_nxt = timer_inc;
               if (timeout) begin
                  state_nxt  = ST_RUN;
                  wakeup_nxt = 1'b1;
                  err_set    = 1'b1;
               end
            end
         end
         default: begin
            state_nxt    = ST_RUN;
            lpmd_out_nxt = 2'b11;
            icg_off_nxt  = 1'b0;
         end
      endcase
      busy_nxt   = (state_nxt != ST_RUN);
      to_err_nxt = err_set ? 1'b1 : (lpmd.sysio_lpmd_err_clr ? 1'b0 : to_err);
   end

   always_ff @(posedge sysio_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state    <= ST_RUN;
         timer    <= 8'd0;
         lpmd_out <= 2'b11;
         icg_off  <= 1'b0;
         wakeup   <= 1'b0;
         busy     <= 1'b0;
         to_err   <= 1'b0;
      end else if (axim_clk_en) begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         lpmd_out <= lpmd_out_nxt;
         icg_off  <= icg_off_nxt;
         wakeup   <= wakeup_nxt;
         busy     <= busy_nxt;
         to_err   <= to_err_nxt;
      end
   end

   assign lpmd.core_pad_lpmd_b   = lpmd_out;
   assign lpmd.sysio_ciu_icg_off = icg_off;
   assign lpmd.sysio_piu_wakeup  = wakeup;
   assign lpmd.sysio_lpmd_busy   = busy;
   assign lpmd.sysio_lpmd_to_err = to_err;

endmodule

// File: tb/tb_ct_sysio_lpmd_ctrl.sv
// Directed bench for the low-power sequencer, run with a short ack timeout.
module tb_ct_sysio_lpmd_ctrl;

   logic sysio_clk;
   logic cpurst_b;
   logic axim_clk_en;
   int   n_chk;
   int   n_err;

   ct_sysio_lpmd_ctrl_if bus ();

   ct_sysio_lpmd_ctrl #(.ACK_TO(8'd4)) dut (
      .sysio_clk   (sysio_clk),
      .cpurst_b    (cpurst_b),
      .axim_clk_en (axim_clk_en),
      .lpmd        (bus)
   );

   initial sysio_clk = 1'b0;
   always #5 sysio_clk = ~sysio_clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_val);
      n_chk++;
      if (obs !== exp_val) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_val, $time);
      end
   endtask

   task automatic tick(input logic en);
      axim_clk_en = en;
      @(posedge sysio_clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic [1:0] out, input logic icg,
                           input logic wk, input logic bsy, input logic err);
      chk({tag, ".lpmd_b"}, {6'd0, bus.core_pad_lpmd_b}, {6'd0, out});
      chk({tag, ".icg_off"}, {7'd0, bus.sysio_ciu_icg_off}, {7'd0, icg});
      chk({tag, ".wakeup"}, {7'd0, bus.sysio_piu_wakeup}, {7'd0, wk});
      chk({tag, ".busy"}, {7'd0, bus.sysio_lpmd_busy}, {7'd0, bsy});
      chk({tag, ".to_err"}, {7'd0, bus.sysio_lpmd_to_err}, {7'd0, err});
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      cpurst_b                = 1'b0;
      axim_clk_en             = 1'b1;
      bus.piu_sysio_lpmd_b    = 2'b11;
      bus.sysio_piu_int_vec   = 6'd0;
      bus.pad_core_dbgrq_b    = 1'b1;
      bus.pad_sysio_lpmd_ack  = 1'b0;
      bus.sysio_lpmd_err_clr  = 1'b0;
      #22;
      chk_outs("reset", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      cpurst_b = 1'b1;
      tick(1'b1);
      chk_outs("idle", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

      // wait-mode entry, ack after 3 cycles, interrupt wake, ack release
      bus.piu_sysio_lpmd_b = 2'b01;
      tick(1'b1);
      chk_outs("wait_enter", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) tick(1'b1);
      chk_outs("wait_pending", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.pad_sysio_lpmd_ack = 1'b1;
      tick(1'b1);
      chk_outs("wait_lowpwr", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      bus.piu_sysio_lpmd_b = 2'b11;
      tick(1'b1);
      chk_outs("lowpwr_ignore_req", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      bus.sysio_piu_int_vec = 6'b000100;
      tick(1'b1);
      chk_outs("wait_exit", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.sysio_piu_int_vec  = 6'd0;
      bus.pad_sysio_lpmd_ack = 1'b0;
      tick(1'b1);
      chk_outs("wait_wakeup", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b1);
      chk_outs("wakeup_end", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

      // stop-mode entry with no ack: abort after 4 cycles in ENTER
      bus.piu_sysio_lpmd_b = 2'b00;
      tick(1'b1);
      chk_outs("stop_enter", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.piu_sysio_lpmd_b = 2'b11;
      repeat (3) tick(1'b1);
      chk_outs("stop_pending", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1);
      chk_outs("stop_timeout", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1);
      chk_outs("err_sticky", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      bus.sysio_lpmd_err_clr = 1'b1;
      tick(1'b1);
      chk_outs("err_clr", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.sysio_lpmd_err_clr = 1'b0;

      // debug request blocks entry; reserved code is treated as run
      bus.piu_sysio_lpmd_b = 2'b01;
      bus.pad_core_dbgrq_b = 1'b0;
      repeat (2) tick(1'b1);
      chk_outs("dbg_block", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.pad_core_dbgrq_b = 1'b1;
      bus.piu_sysio_lpmd_b = 2'b10;
      tick(1'b1);
      chk_outs("reserved_run", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

      // ack and interrupt together in ENTER: wake wins
      bus.piu_sysio_lpmd_b = 2'b01;
      tick(1'b1);
      chk_outs("race_enter", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.piu_sysio_lpmd_b   = 2'b11;
      bus.pad_sysio_lpmd_ack = 1'b1;
      bus.sysio_piu_int_vec  = 6'b100000;
      tick(1'b1);
      chk_outs("race_exit", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.pad_sysio_lpmd_ack = 1'b0;
      bus.sysio_piu_int_vec  = 6'd0;
      tick(1'b1);
      chk_outs("race_wakeup", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);

      // ack stuck high in EXIT: timeout with wakeup; set beats clear
      bus.piu_sysio_lpmd_b = 2'b00;
      tick(1'b1);
      bus.piu_sysio_lpmd_b   = 2'b11;
      bus.pad_sysio_lpmd_ack = 1'b1;
      tick(1'b1);
      chk_outs("stuck_lowpwr", 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      bus.sysio_piu_int_vec = 6'b000001;
      tick(1'b1);
      bus.sysio_piu_int_vec = 6'd0;
      repeat (3) tick(1'b1);
      chk_outs("stuck_exit", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.sysio_lpmd_err_clr = 1'b1;
      tick(1'b1);
      chk_outs("exit_timeout", 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b1);
      chk_outs("exit_err_clr", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.sysio_lpmd_err_clr = 1'b0;
      bus.pad_sysio_lpmd_ack = 1'b0;

      // enable at 1:3 ratio: state moves only on enabled edges
      bus.piu_sysio_lpmd_b = 2'b01;
      tick(1'b1);
      chk_outs("r_enter", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.piu_sysio_lpmd_b   = 2'b11;
      bus.pad_sysio_lpmd_ack = 1'b1;
      tick(1'b0);
      tick(1'b0);
      chk_outs("r_enter_hold", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1);
      chk_outs("r_lowpwr", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      bus.sysio_piu_int_vec = 6'b000001;
      tick(1'b0);
      tick(1'b0);
      chk_outs("r_lowpwr_hold", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b1);
      chk_outs("r_exit", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.sysio_piu_int_vec  = 6'd0;
      bus.pad_sysio_lpmd_ack = 1'b0;
      tick(1'b0);
      tick(1'b0);
      chk_outs("r_exit_hold", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1);
      chk_outs("r_wake0", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b0);
      chk_outs("r_wake1", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b0);
      chk_outs("r_wake2", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b1);
      chk_outs("r_wake_end", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

      // asynchronous reset while in LOWPWR
      bus.piu_sysio_lpmd_b = 2'b01;
      tick(1'b1);
      bus.pad_sysio_lpmd_ack = 1'b1;
      tick(1'b1);
      chk_outs("rst_lowpwr", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      #2;
      cpurst_b = 1'b0;
      #1;
      chk_outs("rst_async", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.piu_sysio_lpmd_b   = 2'b11;
      bus.pad_sysio_lpmd_ack = 1'b0;
      #3;
      cpurst_b = 1'b1;
      tick(1'b1);
      chk_outs("rst_after", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ct_sysio_lpmd_ctrl.md
CT_SYSIO_LPMD_CTRL -- requirements
Module: ct_sysio_lpmd_ctrl

Interface
REQ-001 Parameter ACK_TO, default 8'd255: AXI-clock-enabled cycles allowed for a pad ack before abort (1..255).
REQ-002 sysio_clk  input  1  block clock; all state updates occur on posedge sysio_clk when axim_clk_en=1.
REQ-003 cpurst_b  input  1  asynchronous active-low reset.
REQ-004 axim_clk_en  input  1  AXI-ratio clock enable; sampling and state advance only when 1.
REQ-005 piu_sysio_lpmd_b  input  2  core low-power request: 11 run, 01 wait, 00 stop, 10 reserved (treated as run).
REQ-006 sysio_piu_int_vec  input  6  registered interrupt lines {me,se,ms,ss,mt,st}.
REQ-007 pad_core_dbgrq_b  input  1  debug request, active-low.
REQ-008 pad_sysio_lpmd_ack  input  1  SoC power-controller acknowledge (level).
REQ-009 core_pad_lpmd_b  output  2  low-power mode presented to pad.
REQ-010 sysio_ciu_icg_off  output  1  request to gate core clocks, level.
REQ-011 sysio_piu_wakeup  output  1  one-enabled-cycle wakeup pulse to core.
REQ-012 sysio_lpmd_busy  output  1  1 whenever state is not RUN.
REQ-013 sysio_lpmd_to_err  output  1  sticky ack-timeout flag.
REQ-014 sysio_lpmd_err_clr  input  1  clears sysio_lpmd_to_err.

Function
REQ-015 Block SHALL implement FSM states RUN, ENTER, LOWPWR, EXIT; state and all outputs registered.
REQ-016 wake SHALL be defined as (|sysio_piu_int_vec) | ~pad_core_dbgrq_b, sampled in the same enabled cycle as the FSM.
REQ-017 RUN: if piu_sysio_lpmd_b is 01 or 00 and wake=0, latch mode, drive core_pad_lpmd_b=mode, clear timer, go ENTER next enabled cycle.
REQ-018 RUN with low-power request and wake=1: SHALL stay RUN, core_pad_lpmd_b=11, no pulse.
REQ-019 ENTER: ack=1 and wake=0 -> LOWPWR, assert sysio_ciu_icg_off.
REQ-020 ENTER: wake=1 (priority over ack) -> EXIT, core_pad_lpmd_b=11.
REQ-021 ENTER: timer increments per enabled cycle; timer==ACK_TO with ack=0 -> RUN, core_pad_lpmd_b=11, sysio_lpmd_to_err=1, no wakeup pulse.
REQ-022 LOWPWR: wake=1 -> EXIT, deassert sysio_ciu_icg_off, core_pad_lpmd_b=11, clear timer.
REQ-023 LOWPWR: change of piu_sysio_lpmd_b SHALL be ignored.
REQ-024 EXIT: ack=0 -> RUN and sysio_piu_wakeup=1 for exactly one enabled cycle (held until next enabled edge).
REQ-025 EXIT: timer==ACK_TO with ack=1 -> RUN, sysio_lpmd_to_err=1, wakeup pulse still issued.
REQ-026 Timer 8-bit, SHALL saturate at ACK_TO, never wrap.
REQ-027 sysio_lpmd_err_clr=1 clears error in same enabled cycle; simultaneous set and clear -> set wins.
REQ-028 axim_clk_en=0 cycles SHALL hold all state, timer and outputs unchanged.
REQ-029 sysio_piu_wakeup SHALL be 0 outside the EXIT->RUN transition cycle.

Reset
REQ-030 On cpurst_b=0: state RUN, core_pad_lpmd_b=11, sysio_ciu_icg_off=0, sysio_piu_wakeup=0, sysio_lpmd_busy=0, sysio_lpmd_to_err=0, timer=0.
REQ-031 Reset asserted mid-operation (any state) SHALL return immediately to REQ-030 values without handshake completion.

Verification
REQ-032 lpmd_b=01, ints=0, ack rises 3 enabled cycles later -> lpmd_b out 01, LOWPWR, icg_off=1; int_vec=6'b000100 -> icg_off=0, out 11; ack falls -> RUN, one wakeup pulse.
REQ-033 lpmd_b=00, ack held 0, ACK_TO=4 -> after 4 enabled cycles in ENTER: RUN, out 11, to_err=1, wakeup=0; err_clr=1 -> to_err=0.
REQ-034 lpmd_b=01 with pad_core_dbgrq_b=0 -> remains RUN, out 11, busy=0.
REQ-035 ENTER with ack=1 and int_vec=6'b100000 in same cycle -> EXIT (not LOWPWR), icg_off stays 0.
REQ-036 axim_clk_en toggling 1:3 during full enter/exit sequence -> transitions only on enabled edges; wakeup pulse width = 3 sysio_clk cycles... spanning to next enabled edge.
REQ-037 cpurst_b pulsed low in LOWPWR -> icg_off=0, out 11, busy=0 asynchronously.
